l_class_oc_echoresponder: RTL and testbench

Consumer stage behind the echo FIFO: accepts values through an `enq` method, buffers them in a DEPTH-entry circular queue, and after a programmable pacing delay replays each value, tagged with a sequence number, on a `heard` indication method. It sits directly downstream of the test driver's `enq` call and upstream of the indication sink. Flow control is the codebase's method handshake: `__ENA`/`__RDY` pairs, with a transfer on any cycle where both are high.

---
 rtl/l_class_oc_echoresponder_pkg.sv | 13 +
 rtl/l_class_oc_echoresponder_queue.sv | 53 +++++
 rtl/l_class_oc_echoresponder.sv | 92 +++++++++
 tb/tb_l_class_oc_echoresponder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/l_class_oc_echoresponder_pkg.sv
// Shared definitions for the echo responder: FSM encoding and sequence width,
// reused by the driver and indication sink.
package l_class_oc_echoresponder_pkg;

  localparam int SEQ_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } er_state_t;

endpackage

// File: rtl/l_class_oc_echoresponder_queue.sv
// DEPTH x WIDTH circular buffer with push/pop and registered occupancy.
// Storage is not cleared on reset; only pointers and count are.
module l_class_oc_echoresponder_queue
  import l_class_oc_echoresponder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_v,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_v,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && (count != '0);
  assign head_v  = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok && !nRST) mem[wr_ptr] <= push_v;
  end

endmodule

// File: rtl/l_class_oc_echoresponder.sv
// Echo responder: queues enq values and replays each on the heard indication
// after DELAY idle cycles, tagged with a wrapping sequence number.
module l_class_oc_echoresponder
  import l_class_oc_echoresponder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int DELAY = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   enq__ENA,
  input  logic [WIDTH-1:0]       enq_v,
  output logic                   enq__RDY,
  output logic                   heard__ENA,
  output logic [WIDTH-1:0]       heard_v,
  output logic [SEQ_W-1:0]       heard_seq,
  input  logic                   heard__RDY,
  output logic [$clog2(DEPTH):0] count
);

  localparam logic [7:0] DLY_INIT = 8'(DELAY);

  er_state_t        state_q, state_d;
  logic [7:0]       dly_q, dly_d;
  logic [SEQ_W-1:0] seq_q;
  logic             full;
  logic             push;
  logic             pop;

  assign enq__RDY   = !full;
  assign push       = enq__ENA && enq__RDY;
  assign heard__ENA = (state_q == ST_SEND);
  assign heard_seq  = seq_q;

  l_class_oc_echoresponder_queue #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_queue (
    .CLK    (CLK),
    .nRST   (nRST),
    .push   (push),
    .push_v (enq_v),
    .pop    (pop),
    .head_v (heard_v),
    .full   (full),
    .count  (count)
  );

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // count is registered, so a value pushed this cycle waits a cycle here
        if (count != '0) begin
          if (DELAY == 0) begin
            state_d = ST_SEND;
          end else begin
            state_d = ST_WAIT;
            dly_d   = DLY_INIT;
          end
        end
      end
      ST_WAIT: begin
        dly_d = dly_q - 8'd1;
        if (dly_q == 8'd1) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (heard__RDY) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q <= ST_IDLE;
      dly_q   <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      if (pop) seq_q <= seq_q + SEQ_W'(1);
    end
  end

endmodule

// File: tb/tb_l_class_oc_echoresponder.sv
// Directed bench for the echo responder: default DELAY=2 instance plus a DELAY=0
// instance sharing the same stimulus.
module tb_l_class_oc_echoresponder;

  logic        CLK;
  logic        nRST;
  logic        enq_ena;
  logic [31:0] enq_v;
  logic        heard_rdy;

  logic        rdy2, ena2, rdy0, ena0;
  logic [31:0] v2, v0;
  logic [15:0] seq2, seq0;
  logic [2:0]  cnt2, cnt0;

  int n_total = 0;
  int n_pass  = 0;

  l_class_oc_echoresponder #(.DEPTH(4), .WIDTH(32), .DELAY(2)) u_dut (
    .CLK(CLK), .nRST(nRST), .enq__ENA(enq_ena), .enq_v(enq_v), .enq__RDY(rdy2),
    .heard__ENA(ena2), .heard_v(v2), .heard_seq(seq2), .heard__RDY(heard_rdy), .count(cnt2)
  );

  l_class_oc_echoresponder #(.DEPTH(4), .WIDTH(32), .DELAY(0)) u_dut0 (
    .CLK(CLK), .nRST(nRST), .enq__ENA(enq_ena), .enq_v(enq_v), .enq__RDY(rdy0),
    .heard__ENA(ena0), .heard_v(v0), .heard_seq(seq0), .heard__RDY(heard_rdy), .count(cnt0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    nRST      = 1'b1;
    enq_ena   = 1'b0;
    enq_v     = '0;
    heard_rdy = 1'b1;
    tick();
    tick();
    nRST = 1'b0;
  endtask

  task automatic wait_ena(input bit z, input string tag, output int n);
    n = 0;
    while (((z ? ena0 : ena2) !== 1'b1) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " ena"}, {31'd0, (z ? ena0 : ena2)}, 32'd1);
  endtask

  initial begin
    int n;
    logic [31:0] exp_v0 [3];
    exp_v0[0] = 32'hA; exp_v0[1] = 32'hB; exp_v0[2] = 32'hC;

    // single value with defaults
    do_reset();
    chk("rst enq_rdy", {31'd0, rdy2}, 32'd1);
    chk("rst ena", {31'd0, ena2}, 32'd0);
    chk("rst seq", {16'd0, seq2}, 32'd0);
    chk("rst count", {29'd0, cnt2}, 32'd0);
    enq_ena = 1'b1; enq_v = 32'd22;
    for (int c = 1; c <= 5; c++) begin
      tick();
      enq_ena = 1'b0;
      chk($sformatf("single ena c%0d", c), {31'd0, ena2}, {31'd0, (c == 4)});
      if (c == 1) chk("single count", {29'd0, cnt2}, 32'd1);
      if (c == 4) begin
        chk("single v", v2, 32'd22);
        chk("single seq", {16'd0, seq2}, 32'd0);
      end
    end
    chk("single count end", {29'd0, cnt2}, 32'd0);
    chk("single enq_rdy end", {31'd0, rdy2}, 32'd1);

    // fill under backpressure
    do_reset();
    heard_rdy = 1'b0;
    enq_ena   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("fill enq_rdy %0d", i), {31'd0, rdy2}, {31'd0, (i < 4)});
      enq_v = 32'(i + 1);
      tick();
    end
    enq_ena = 1'b0;
    chk("fill count", {29'd0, cnt2}, 32'd4);
    chk("fill enq_rdy", {31'd0, rdy2}, 32'd0);
    chk("fill ena", {31'd0, ena2}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall v %0d", i), v2, 32'd1);
      chk($sformatf("stall seq %0d", i), {16'd0, seq2}, 32'd0);
      tick();
    end
    chk("stall ena", {31'd0, ena2}, 32'd1);

    // push and pop together while full: push refused
    heard_rdy = 1'b1;
    enq_ena = 1'b1; enq_v = 32'd5;
    tick();
    enq_ena = 1'b0;
    chk("fullpp count", {29'd0, cnt2}, 32'd3);
    chk("fullpp enq_rdy", {31'd0, rdy2}, 32'd1);
    chk("fullpp ena", {31'd0, ena2}, 32'd0);
    for (int k = 2; k <= 4; k++) begin
      wait_ena(1'b0, $sformatf("drain %0d", k), n);
      chk($sformatf("drain gap %0d", k), n, 32'd3);
      chk($sformatf("drain v %0d", k), v2, 32'(k));
      chk($sformatf("drain seq %0d", k), {16'd0, seq2}, 32'(k - 1));
      tick();
    end
    for (int i = 0; i < 6; i++) tick();
    chk("drain no extra ena", {31'd0, ena2}, 32'd0);
    chk("drain count", {29'd0, cnt2}, 32'd0);

    // DELAY=0 streaming
    do_reset();
    for (int c = 0; c < 8; c++) begin
      enq_ena = (c < 3);
      enq_v   = (c < 3) ? exp_v0[c] : 32'd0;
      chk($sformatf("d0 ena c%0d", c), {31'd0, ena0}, {31'd0, (c == 2 || c == 4 || c == 6)});
      if (c == 2 || c == 4 || c == 6)
        chk($sformatf("d0 v c%0d", c), v0, exp_v0[(c / 2) - 1]);
      tick();
    end
    enq_ena = 1'b0;
    chk("d0 seq end", {16'd0, seq0}, 32'd3);

    // reset during WAIT discards queued data
    do_reset();
    enq_ena = 1'b1; enq_v = 32'd7;
    tick();
    enq_ena = 1'b0;
    tick();
    nRST = 1'b1;
    tick();
    nRST = 1'b0;
    chk("midrst count", {29'd0, cnt2}, 32'd0);
    chk("midrst seq", {16'd0, seq2}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("midrst ena %0d", i), {31'd0, ena2}, 32'd0);
      tick();
    end
    enq_ena = 1'b1; enq_v = 32'd9;
    tick();
    enq_ena = 1'b0;
    wait_ena(1'b0, "midrst9", n);
    chk("midrst9 v", v2, 32'd9);
    chk("midrst9 seq", {16'd0, seq2}, 32'd0);
    tick();

    // sequence wrap
    force u_dut.seq_q = 16'hFFFF;
    tick();
    release u_dut.seq_q;
    tick();
    chk("wrap preload", {16'd0, seq2}, 32'h0000FFFF);
    enq_ena = 1'b1; enq_v = 32'h11;
    tick();
    enq_v = 32'h22;
    tick();
    enq_ena = 1'b0;
    wait_ena(1'b0, "wrap1", n);
    chk("wrap1 v", v2, 32'h11);
    chk("wrap1 seq", {16'd0, seq2}, 32'h0000FFFF);
    tick();
    wait_ena(1'b0, "wrap2", n);
    chk("wrap2 v", v2, 32'h22);
    chk("wrap2 seq", {16'd0, seq2}, 32'h00000000);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
